memory_access_controller: RTL and testbench

- Sequencer that sits directly downstream of the memory data/address register in the CPU datapath.
- Accepts one latched address (16 b) plus write data (32 b) and runs a single read or write transaction against a synchronous word-addressed RAM with fixed wait states.
- Returns read data and a one-cycle completion pulse to the control unit.
- One transaction outstanding at a time; handshake-driven, no buffering beyond one request.

---
 rtl/cpu_mem_pkg.sv | 16 +
 rtl/memory_access_controller_if.sv | 41 ++++
 rtl/mem_wait_counter.sv | 39 +++
 rtl/memory_access_controller.sv | 143 ++++++++++++++
 tb/tb_memory_access_controller.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and width defaults for the memory access controller and the
// register stage that feeds it.
package cpu_mem_pkg;

  localparam int unsigned BITS_DATA_DEFAULT = 32;
  localparam int unsigned BITS_ADDR_DEFAULT = 16;
  localparam int unsigned BITS_WAIT         = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

endpackage

// File: rtl/memory_access_controller_if.sv
// Control-unit request/response handshake plus the RAM bus, bundled for the controller.
// The err signal exists only when MEM_RANGE_CHECK_EN is defined.
interface memory_access_controller_if #(
  parameter int unsigned BITS_DATA = cpu_mem_pkg::BITS_DATA_DEFAULT,
  parameter int unsigned BITS_ADDR = cpu_mem_pkg::BITS_ADDR_DEFAULT
);

  logic                 req;
  logic                 we;
  logic [BITS_ADDR-1:0] addrIn;
  logic [BITS_DATA-1:0] dataIn;
  logic                 busy;
  logic                 done;
  logic [BITS_DATA-1:0] dataOut;
  logic                 memEn;
  logic                 memWe;
  logic [BITS_ADDR-1:0] memAddr;
  logic [BITS_DATA-1:0] memWdata;
  logic [BITS_DATA-1:0] memRdata;
`ifdef MEM_RANGE_CHECK_EN
  logic                 err;
`endif

  // Control unit plus RAM: everything the controller consumes.
  modport master (
`ifdef MEM_RANGE_CHECK_EN
    input  err,
`endif
    output req, we, addrIn, dataIn, memRdata,
    input  busy, done, dataOut, memEn, memWe, memAddr, memWdata
  );

  modport slave (
`ifdef MEM_RANGE_CHECK_EN
    output err,
`endif
    input  req, we, addrIn, dataIn, memRdata,
    output busy, done, dataOut, memEn, memWe, memAddr, memWdata
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter that times the RAM wait states.
// terminal is high while the count is 1, i.e. in the last wait cycle.
module mem_wait_counter
  import cpu_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [BITS_WAIT-1:0] load_val,
  input  logic                 en,
  output logic [BITS_WAIT-1:0] value,
  output logic                 terminal
);

  logic [BITS_WAIT-1:0] count_d, count_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign value    = count_q;
  assign terminal = (count_q == BITS_WAIT'(1));

endmodule

// File: rtl/memory_access_controller.sv
// Single-outstanding read/write sequencer between the CPU address/data registers
// and a synchronous RAM with fixed wait states. Optional: MEM_RANGE_CHECK_EN.
module memory_access_controller
  import cpu_mem_pkg::*;
#(
  parameter int unsigned BITS_DATA   = BITS_DATA_DEFAULT,
  parameter int unsigned BITS_ADDR   = BITS_ADDR_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned MEM_DEPTH   = 65536
) (
  input  logic                       clk,
  input  logic                       rst_n,
  memory_access_controller_if.slave  bus
);

  localparam logic [BITS_WAIT-1:0] WAIT_LOAD = BITS_WAIT'(WAIT_CYCLES);

  if (WAIT_CYCLES > 15 || MEM_DEPTH == 0) begin : g_param_check
    $error("memory_access_controller: WAIT_CYCLES must be 0..15 and MEM_DEPTH nonzero");
  end

  mem_state_t           state_d, state_q;
  logic                 we_d, we_q;
  logic [BITS_ADDR-1:0] addr_d, addr_q;
  logic [BITS_DATA-1:0] wdata_d, wdata_q;
  logic [BITS_DATA-1:0] rdata_d, rdata_q;

  logic                 busy, done, mem_en, mem_we;
  logic                 cnt_load, cnt_en, cnt_terminal;
  logic [BITS_WAIT-1:0] cnt_value;

`ifdef MEM_RANGE_CHECK_EN
  logic oor_d, oor_q;
`endif

  mem_wait_counter u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .en       (cnt_en),
    .value    (cnt_value),
    .terminal (cnt_terminal)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
    oor_d    = oor_q;
`endif

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addrIn;
          wdata_d = bus.dataIn;
          state_d = ACCESS;
`ifdef MEM_RANGE_CHECK_EN
          // Out-of-range requests never touch the RAM; they just report err in DONE.
          oor_d = (32'(bus.addrIn) >= MEM_DEPTH);
          if (oor_d) state_d = DONE;
`endif
        end
      end

      ACCESS: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        cnt_load = 1'b1;
        if (WAIT_CYCLES == 0) begin
          state_d = DONE;
          if (!we_q) rdata_d = bus.memRdata;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        mem_en = 1'b1;
        mem_we = we_q;
        cnt_en = 1'b1;
        // A zero count here could only follow a bad load; leave rather than hang.
        if (cnt_terminal || (cnt_value == '0)) begin
          state_d = DONE;
          if (!we_q) rdata_d = bus.memRdata;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_RANGE_CHECK_EN
      oor_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_RANGE_CHECK_EN
      oor_q   <= oor_d;
`endif
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.dataOut  = rdata_q;
  assign bus.memEn    = mem_en;
  assign bus.memWe    = mem_we;
  assign bus.memAddr  = addr_q;
  assign bus.memWdata = wdata_q;
`ifdef MEM_RANGE_CHECK_EN
  assign bus.err      = done && oor_q;
`endif

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench: 2-wait-state controller (MEM_DEPTH 1024) plus a zero-wait instance,
// each against a small combinational-read RAM model.
module tb_memory_access_controller;

  logic clk;
  logic rst_n;

  memory_access_controller_if #(.BITS_DATA(32), .BITS_ADDR(16)) bus  ();
  memory_access_controller_if #(.BITS_DATA(32), .BITS_ADDR(16)) bus0 ();

  memory_access_controller #(
    .BITS_DATA(32), .BITS_ADDR(16), .WAIT_CYCLES(2), .MEM_DEPTH(1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  memory_access_controller #(
    .BITS_DATA(32), .BITS_ADDR(16), .WAIT_CYCLES(0), .MEM_DEPTH(1024)
  ) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: write on the clock edge, read data only while enabled.
  logic [31:0] ram  [1024];
  logic [31:0] ram0 [1024];

  always @(posedge clk) begin
    if (bus.memEn && bus.memWe) ram[bus.memAddr[9:0]] <= bus.memWdata;
    if (bus0.memEn && bus0.memWe) ram0[bus0.memAddr[9:0]] <= bus0.memWdata;
  end

  assign bus.memRdata  = bus.memEn  ? ram[bus.memAddr[9:0]]   : 32'hBAD0_BAD0;
  assign bus0.memRdata = bus0.memEn ? ram0[bus0.memAddr[9:0]] : 32'hBAD0_BAD0;

  logic saw_30;
  initial saw_30 = 1'b0;
  always @(negedge clk) if (bus.memAddr == 16'h0030) saw_30 = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-transaction observations on the main instance.
  int          r_done_at, r_en_cnt, r_done_cnt, r_err_cnt;
  logic [31:0] r_dout;
  logic [15:0] r_addr1;
  logic [31:0] r_wdata1;
  logic        r_we1, r_busy1, r_busy_end;

  // Present one request, scramble the inputs afterwards, and watch 12 cycles.
  // pulse_k > 0 raises a one-cycle stray req (addr 0x0030) in that cycle.
  task automatic run_txn(input logic w, input logic [15:0] a, input logic [31:0] d,
                         input int pulse_k);
    r_done_at = 0; r_en_cnt = 0; r_done_cnt = 0; r_err_cnt = 0; r_dout = '0;
    bus.req = 1'b1; bus.we = w; bus.addrIn = a; bus.dataIn = d;
    tick();
    bus.req = 1'b0; bus.we = ~w; bus.addrIn = ~a; bus.dataIn = ~d;
    for (int k = 1; k <= 12; k++) begin
      if (bus.memEn) r_en_cnt++;
`ifdef MEM_RANGE_CHECK_EN
      if (bus.err) r_err_cnt++;
`endif
      if (bus.done) begin
        r_done_cnt++;
        if (r_done_at == 0) begin
          r_done_at = k;
          r_dout    = bus.dataOut;
        end
      end
      if (k == 1) begin
        r_addr1 = bus.memAddr; r_wdata1 = bus.memWdata; r_we1 = bus.memWe; r_busy1 = bus.busy;
      end
      if (k == pulse_k) begin
        bus.req = 1'b1; bus.addrIn = 16'h0030;
      end else begin
        bus.req = 1'b0;
      end
      tick();
    end
    r_busy_end = bus.busy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] done_mask, en_mask, busy_mask, dout_a, dout_b;

    bus.req = 1'b0;  bus.we = 1'b0;  bus.addrIn = '0;  bus.dataIn = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addrIn = '0; bus0.dataIn = '0;
    ram[16'h0040 & 10'h3FF] = 32'h0;
    ram[10'h3FF] = 32'h5A5A_03FF;
    ram0[5] = 32'hA5A5_0005;
    ram0[6] = 32'hA5A5_0006;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy",     32'(bus.busy),  32'd0);
    check("rst_done",     32'(bus.done),  32'd0);
    check("rst_memEn",    32'(bus.memEn), 32'd0);
    check("rst_memWe",    32'(bus.memWe), 32'd0);
    check("rst_dataOut",  bus.dataOut,    32'h0);
    check("rst_memAddr",  32'(bus.memAddr), 32'h0);
    check("rst_memWdata", bus.memWdata,   32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Write 0xDEADBEEF to 0x0010.
    run_txn(1'b1, 16'h0010, 32'hDEAD_BEEF, 0);
    check("wr_memAddr",   32'(r_addr1), 32'h0010);
    check("wr_memWdata",  r_wdata1,     32'hDEAD_BEEF);
    check("wr_memWe",     32'(r_we1),   32'd1);
    check("wr_busy",      32'(r_busy1), 32'd1);
    check("wr_done_at",   32'(r_done_at), 32'd4);
    check("wr_en_cycles", 32'(r_en_cnt),  32'd3);
    check("wr_done_cnt",  32'(r_done_cnt), 32'd1);
    check("wr_dataOut",   r_dout,       32'h0);
    check("wr_busy_end",  32'(r_busy_end), 32'd0);
`ifdef MEM_RANGE_CHECK_EN
    check("wr_err_cnt",   32'(r_err_cnt), 32'd0);
`endif

    // Read it back; data must be valid in the done cycle.
    run_txn(1'b0, 16'h0010, 32'h0, 0);
    check("rd_memWe",     32'(r_we1),     32'd0);
    check("rd_done_at",   32'(r_done_at), 32'd4);
    check("rd_en_cycles", 32'(r_en_cnt),  32'd3);
    check("rd_dataOut",   r_dout,         32'hDEAD_BEEF);

    // A write must not disturb dataOut.
    run_txn(1'b1, 16'h0020, 32'h1234_5678, 0);
    check("wr2_dataOut_at_done", r_dout,      32'hDEAD_BEEF);
    check("wr2_dataOut_after",   bus.dataOut, 32'hDEAD_BEEF);
    run_txn(1'b0, 16'h0020, 32'h0, 0);
    check("rd2_dataOut",  r_dout,         32'h1234_5678);

    // Stray req during WAIT, then during DONE: both ignored.
    run_txn(1'b1, 16'h0040, 32'h0BAD_CAFE, 2);
    check("bsy_wait_done_cnt", 32'(r_done_cnt), 32'd1);
    check("bsy_wait_en_cycles", 32'(r_en_cnt),  32'd3);
    run_txn(1'b0, 16'h0040, 32'h0, 4);
    check("bsy_done_done_cnt", 32'(r_done_cnt), 32'd1);
    check("bsy_done_dataOut",  r_dout,          32'h0BAD_CAFE);
    check("bsy_no_addr_30",    32'(saw_30),     32'd0);

    // Zero wait states, req held high: IDLE, ACCESS, DONE repeating.
    done_mask = '0; en_mask = '0; busy_mask = '0; dout_a = '0; dout_b = '0;
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addrIn = 16'h0005;
    tick();
    for (int k = 1; k <= 9; k++) begin
      if (bus0.done)  done_mask[k] = 1'b1;
      if (bus0.memEn) en_mask[k]   = 1'b1;
      if (bus0.busy)  busy_mask[k] = 1'b1;
      if (k == 2) dout_a = bus0.dataOut;
      if (k == 5) dout_b = bus0.dataOut;
      if (k == 3) bus0.addrIn = 16'h0006;
      if (k == 9) bus0.req = 1'b0;
      tick();
    end
    check("zw_done_mask", done_mask, 32'h0000_0124);
    check("zw_en_mask",   en_mask,   32'h0000_0092);
    check("zw_busy_mask", busy_mask, 32'h0000_01B6);
    check("zw_dout_1",    dout_a,    32'hA5A5_0005);
    check("zw_dout_2",    dout_b,    32'hA5A5_0006);

`ifdef MEM_RANGE_CHECK_EN
    // Out-of-range read: straight to DONE with err, RAM untouched.
    run_txn(1'b0, 16'h0400, 32'h0, 0);
    check("oor_en_cycles", 32'(r_en_cnt),   32'd0);
    check("oor_done_at",   32'(r_done_at),  32'd1);
    check("oor_err_cnt",   32'(r_err_cnt),  32'd1);
    check("oor_done_cnt",  32'(r_done_cnt), 32'd1);
    check("oor_dataOut",   r_dout,          32'h0BAD_CAFE);
    run_txn(1'b0, 16'h03FF, 32'h0, 0);
    check("inr_done_at",   32'(r_done_at),  32'd4);
    check("inr_err_cnt",   32'(r_err_cnt),  32'd0);
    check("inr_dataOut",   r_dout,          32'h5A5A_03FF);
`endif

    // Reset mid-WAIT of a write to 0x0010: outputs clear with no clock edge.
    bus.req = 1'b1; bus.we = 1'b1; bus.addrIn = 16'h0010; bus.dataIn = 32'hCAFE_F00D;
    tick();
    bus.req = 1'b0;
    tick();
    check("mid_wait_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",     32'(bus.busy),    32'd0);
    check("arst_done",     32'(bus.done),    32'd0);
    check("arst_memEn",    32'(bus.memEn),   32'd0);
    check("arst_memWe",    32'(bus.memWe),   32'd0);
    check("arst_memAddr",  32'(bus.memAddr), 32'h0);
    check("arst_dataOut",  bus.dataOut,      32'h0);
    check("arst_zw_memAddr", 32'(bus0.memAddr), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
